// File: rtl/uartprobe_pkg.sv
// Shared uartprobe definitions: command codes, command classes, arbiter states.
// Used by the probe, the request arbiter and its command-class decoder.
package uartprobe_pkg;

  localparam logic [5:0] CMD_RD0_LO = 6'h02;
  localparam logic [5:0] CMD_RD0_HI = 6'h09;
  localparam logic [5:0] CMD_WR0_LO = 6'h0A;
  localparam logic [5:0] CMD_WR0_HI = 6'h0D;
  localparam logic [5:0] CMD_RD1_LO = 6'h0E;
  localparam logic [5:0] CMD_RD1_HI = 6'h11;
  localparam logic [5:0] CMD_WR1_LO = 6'h12;
  localparam logic [5:0] CMD_WR1_HI = 6'h15;
  localparam logic [5:0] CMD_RD2_LO = 6'h16;
  localparam logic [5:0] CMD_RD2_HI = 6'h19;
  localparam logic [5:0] CMD_WR2_LO = 6'h1A;
  localparam logic [5:0] CMD_WR2_HI = 6'h1D;
  localparam logic [5:0] CMD_RD3    = 6'h1E;
  localparam logic [5:0] CMD_WR3    = 6'h1F;
  localparam logic [5:0] CMD_RD4    = 6'h20;
  localparam logic [5:0] CMD_WR4    = 6'h21;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_READ  = 2'd1,
    CLS_WRITE = 2'd2
  } cls_e;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_CMD  = 3'd1,
    ARB_DATA = 3'd2,
    ARB_RESP = 3'd3,
    ARB_DONE = 3'd4
  } arb_state_e;

  function automatic logic in_rng(
    input logic [5:0] v,
    input logic [5:0] lo,
    input logic [5:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/uartprobe_cmd_class.sv
// Combinational 6-bit command -> class decoder.
// Mirrors the probe's own decode so the arbiter knows how many bytes follow.
module uartprobe_cmd_class
  import uartprobe_pkg::*;
(
  input  logic [5:0] cmd,
  output cls_e       cls
);

  logic is_rd;
  logic is_wr;

  always_comb begin
    is_rd = in_rng(cmd, CMD_RD0_LO, CMD_RD0_HI)
          | in_rng(cmd, CMD_RD1_LO, CMD_RD1_HI)
          | in_rng(cmd, CMD_RD2_LO, CMD_RD2_HI)
          | (cmd == CMD_RD3)
          | (cmd == CMD_RD4);
    is_wr = in_rng(cmd, CMD_WR0_LO, CMD_WR0_HI)
          | in_rng(cmd, CMD_WR1_LO, CMD_WR1_HI)
          | in_rng(cmd, CMD_WR2_LO, CMD_WR2_HI)
          | (cmd == CMD_WR3)
          | (cmd == CMD_WR4);
    cls = CLS_NONE;
    unique case (1'b1)
      is_rd:   cls = CLS_READ;
      is_wr:   cls = CLS_WRITE;
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/uartprobe_arb.sv
// Two-requester, per-command round-robin arbiter for the uartprobe byte port.
// Define UARTPROBE_ARB_STATS_EN to add saturating per-requester counters.
module uartprobe_arb
  import uartprobe_pkg::*;
#(
  parameter logic        LAST_ON_RESET = 1'b1,
  parameter int unsigned STAT_W        = 16
) (
  input  logic              clk,
  input  logic              m_areset,
  input  logic              s0_rx_valid,
  input  logic [7:0]        s0_rx_data,
  output logic              s0_rx_ready,
  output logic              s0_tx_valid,
  output logic [7:0]        s0_tx_data,
  input  logic              s0_tx_ready,
  input  logic              s1_rx_valid,
  input  logic [7:0]        s1_rx_data,
  output logic              s1_rx_ready,
  output logic              s1_tx_valid,
  output logic [7:0]        s1_tx_data,
  input  logic              s1_tx_ready,
  output logic              m_rx_valid,
  output logic [7:0]        m_rx_data,
  input  logic              m_rx_ready,
  input  logic              m_tx_valid,
  input  logic [7:0]        m_tx_data,
  output logic              m_tx_ready,
  output logic [1:0]        grant
`ifdef UARTPROBE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat0,
  output logic [STAT_W-1:0] stat1
`endif
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  cls_e       cls;
  logic       fwd;
  logic       rsp;
  logic       rx_xfer;
  logic       tx_xfer;

  uartprobe_cmd_class u_cls (
    .cmd (m_rx_data[5:0]),
    .cls (cls)
  );

  assign fwd     = (state_q == ARB_CMD) || (state_q == ARB_DATA);
  assign rsp     = (state_q == ARB_RESP);
  assign rx_xfer = m_rx_valid & m_rx_ready;
  assign tx_xfer = m_tx_valid & m_tx_ready;

  always_ff @(posedge clk) begin
    if (m_areset) begin
      state_q <= ARB_IDLE;
      grant_q <= 2'b00;
      last_q  <= LAST_ON_RESET;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (s0_rx_valid || s1_rx_valid) begin
          state_d = ARB_CMD;
          // On a tie the requester that did not go last wins.
          if (s0_rx_valid && s1_rx_valid)
            grant_d = last_q ? 2'b01 : 2'b10;
          else
            grant_d = s0_rx_valid ? 2'b01 : 2'b10;
        end
      end
      ARB_CMD: begin
        if (rx_xfer) begin
          unique case (cls)
            CLS_READ:  state_d = ARB_RESP;
            CLS_WRITE: state_d = ARB_DATA;
            default:   state_d = ARB_DONE;
          endcase
        end
      end
      ARB_DATA: if (rx_xfer) state_d = ARB_DONE;
      ARB_RESP: if (tx_xfer) state_d = ARB_DONE;
      ARB_DONE: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = ARB_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    s0_rx_ready = 1'b0;
    s0_tx_valid = 1'b0;
    s0_tx_data  = 8'h00;
    s1_rx_ready = 1'b0;
    s1_tx_valid = 1'b0;
    s1_tx_data  = 8'h00;
    m_rx_valid  = 1'b0;
    m_rx_data   = 8'h00;
    m_tx_ready  = 1'b0;
    grant       = grant_q;
    if (fwd && grant_q[0]) begin
      m_rx_valid  = s0_rx_valid;
      m_rx_data   = s0_rx_data;
      s0_rx_ready = m_rx_ready;
    end
    if (fwd && grant_q[1]) begin
      m_rx_valid  = s1_rx_valid;
      m_rx_data   = s1_rx_data;
      s1_rx_ready = m_rx_ready;
    end
    if (rsp && grant_q[0]) begin
      s0_tx_valid = m_tx_valid;
      s0_tx_data  = m_tx_data;
      m_tx_ready  = s0_tx_ready;
    end
    if (rsp && grant_q[1]) begin
      s1_tx_valid = m_tx_valid;
      s1_tx_data  = m_tx_data;
      m_tx_ready  = s1_tx_ready;
    end
  end

`ifdef UARTPROBE_ARB_STATS_EN
  logic [STAT_W-1:0] stat0_q, stat0_d;
  logic [STAT_W-1:0] stat1_q, stat1_d;

  always_ff @(posedge clk) begin
    if (m_areset) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (state_q == ARB_DONE && grant_q[0] && stat0_q != '1)
      stat0_d = stat0_q + STAT_W'(1);
    if (state_q == ARB_DONE && grant_q[1] && stat1_q != '1)
      stat1_d = stat1_q + STAT_W'(1);
  end

  assign stat0 = stat0_q;
  assign stat1 = stat1_q;
`endif

endmodule

// File: tb/tb_uartprobe_arb.sv
// Directed bench for uartprobe_arb: table of single commands plus
// hand-written sequences for alternation, stalls and reset mid-command.
module tb_uartprobe_arb;
  import uartprobe_pkg::*;

  logic       clk = 1'b0;
  logic       m_areset;
  logic       s0_rx_valid, s0_rx_ready, s0_tx_valid, s0_tx_ready;
  logic [7:0] s0_rx_data, s0_tx_data;
  logic       s1_rx_valid, s1_rx_ready, s1_tx_valid, s1_tx_ready;
  logic [7:0] s1_rx_data, s1_tx_data;
  logic       m_rx_valid, m_rx_ready, m_tx_valid, m_tx_ready;
  logic [7:0] m_rx_data, m_tx_data;
  logic [1:0] grant;
`ifdef UARTPROBE_ARB_STATS_EN
  logic [15:0] stat0, stat1;
`endif
  logic [7:0] ref_cmd;
  cls_e       ref_cls;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uartprobe_arb dut (
    .clk         (clk),
    .m_areset    (m_areset),
    .s0_rx_valid (s0_rx_valid),
    .s0_rx_data  (s0_rx_data),
    .s0_rx_ready (s0_rx_ready),
    .s0_tx_valid (s0_tx_valid),
    .s0_tx_data  (s0_tx_data),
    .s0_tx_ready (s0_tx_ready),
    .s1_rx_valid (s1_rx_valid),
    .s1_rx_data  (s1_rx_data),
    .s1_rx_ready (s1_rx_ready),
    .s1_tx_valid (s1_tx_valid),
    .s1_tx_data  (s1_tx_data),
    .s1_tx_ready (s1_tx_ready),
    .m_rx_valid  (m_rx_valid),
    .m_rx_data   (m_rx_data),
    .m_rx_ready  (m_rx_ready),
    .m_tx_valid  (m_tx_valid),
    .m_tx_data   (m_tx_data),
    .m_tx_ready  (m_tx_ready),
    .grant       (grant)
`ifdef UARTPROBE_ARB_STATS_EN
    ,
    .stat0       (stat0),
    .stat1       (stat1)
`endif
  );

  uartprobe_cmd_class u_ref (
    .cmd (ref_cmd[5:0]),
    .cls (ref_cls)
  );

  typedef struct {
    int         who;
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] rsp;
    cls_e       cls;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return {s0_rx_ready, s0_tx_valid, s0_tx_data,
            s1_rx_ready, s1_tx_valid, s1_tx_data,
            m_rx_valid, m_rx_data, m_tx_ready, grant};
  endfunction

  task automatic drive_rx(input int who, input logic v, input logic [7:0] d);
    if (who == 0) begin
      s0_rx_valid = v;
      s0_rx_data  = d;
    end else begin
      s1_rx_valid = v;
      s1_rx_data  = d;
    end
  endtask

  task automatic clear_in();
    s0_rx_valid = 0; s0_rx_data = 0; s0_tx_ready = 0;
    s1_rx_valid = 0; s1_rx_data = 0; s1_tx_ready = 0;
    m_rx_ready  = 0; m_tx_valid = 0; m_tx_data  = 0;
  endtask

  task automatic do_reset();
    clear_in();
    m_areset = 1;
    step();
    step();
    m_areset = 0;
  endtask

  task automatic xact(input vec_t v);
    logic [1:0] g;
    g = (v.who == 0) ? 2'b01 : 2'b10;
    ref_cmd = v.cmd;
    #1;
    chk("cls_decode", ref_cls, v.cls);
    m_rx_ready  = 1;
    s0_tx_ready = 1;
    s1_tx_ready = 1;
    drive_rx(v.who, 1, v.cmd);
    step();
    chk("x_grant", grant, g);
    chk("x_cmd_byte", {m_rx_valid, m_rx_data}, {1'b1, v.cmd});
    chk("x_other_ready", (v.who == 0) ? s1_rx_ready : s0_rx_ready, 0);
    step();
    if (v.cls == CLS_WRITE) begin
      drive_rx(v.who, 1, v.dat);
      #1;
      chk("x_data_byte", {m_rx_valid, m_rx_data}, {1'b1, v.dat});
      chk("x_no_tx", {s0_tx_valid, s1_tx_valid, m_tx_ready}, 0);
      step();
      drive_rx(v.who, 0, 8'h00);
    end else if (v.cls == CLS_READ) begin
      drive_rx(v.who, 0, 8'h00);
      m_tx_valid = 1;
      m_tx_data  = v.rsp;
      #1;
      chk("x_resp", (v.who == 0) ? {s0_tx_valid, s0_tx_data}
                                 : {s1_tx_valid, s1_tx_data},
          {1'b1, v.rsp});
      chk("x_resp_other", (v.who == 0) ? s1_tx_valid : s0_tx_valid, 0);
      step();
      m_tx_valid = 0;
      m_tx_data  = 0;
    end else begin
      drive_rx(v.who, 0, 8'h00);
    end
    #1;
    chk("x_done_grant", grant, g);
    step();
    chk("x_idle_grant", grant, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic ok;
    vt[0] = '{0, 8'h02, 8'h00, 8'h55, CLS_READ};
    vt[1] = '{1, 8'h0A, 8'h3C, 8'h00, CLS_WRITE};
    vt[2] = '{0, 8'h00, 8'h00, 8'h00, CLS_NONE};
    vt[3] = '{0, 8'h42, 8'h00, 8'h55, CLS_READ};
    vt[4] = '{1, 8'h21, 8'hA7, 8'h00, CLS_WRITE};
    vt[5] = '{1, 8'h20, 8'h00, 8'h9E, CLS_READ};
    vt[6] = '{0, 8'h3F, 8'h00, 8'h00, CLS_NONE};
    vt[7] = '{1, 8'h1E, 8'h00, 8'h13, CLS_READ};
    ref_cmd = 0;

    // Reset with live inputs, then a stray m_tx_valid in IDLE.
    clear_in();
    m_areset = 1;
    s0_rx_valid = 1;
    m_tx_valid = 1;
    s0_tx_ready = 1;
    step();
    step();
    chk("reset_outputs", all_out(), 0);
`ifdef UARTPROBE_ARB_STATS_EN
    chk("reset_stats", {stat0, stat1}, 0);
`endif
    s0_rx_valid = 0;
    m_areset = 0;
    step();
    chk("stray_tx_ready", {m_tx_ready, s0_tx_valid, grant}, 0);
    m_tx_valid = 0;
    step();

    for (int i = 0; i < 8; i++) xact(vt[i]);
`ifdef UARTPROBE_ARB_STATS_EN
    chk("stat0_table", stat0, 4);
    chk("stat1_table", stat1, 4);
`endif

    // Both requesters stream READ 0x06: grants must alternate.
    do_reset();
    s0_rx_valid = 1; s0_rx_data = 8'h06;
    s1_rx_valid = 1; s1_rx_data = 8'h06;
    m_rx_ready = 1; m_tx_valid = 1; m_tx_data = 8'hC3;
    s0_tx_ready = 1; s1_tx_ready = 1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (grant == 2'b00 && n < 10) begin step(); n++; end
      chk("alt_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_other_ready",
          (grant == 2'b01) ? s1_rx_ready : s0_rx_ready, 0);
      if (k == 7) begin
        step();
        s0_rx_valid = 0;
        s1_rx_valid = 0;
      end
      n = 0;
      while (grant != 2'b00 && n < 10) begin step(); n++; end
      chk("alt_release", grant, 0);
    end

    // s0 WRITE stalls 50 cycles before its data while s1 waits.
    do_reset();
    m_rx_ready = 1;
    s0_rx_valid = 1; s0_rx_data = 8'h12;
    s1_rx_valid = 1; s1_rx_data = 8'h02;
    step();
    chk("stall_grant0", grant, 2'b01);
    step();
    s0_rx_valid = 0;
    ok = 1;
    repeat (50) begin
      step();
      if (s1_rx_ready !== 1'b0 || grant !== 2'b01 || m_rx_valid !== 1'b0)
        ok = 0;
    end
    chk("stall_hold", ok, 1);
    s0_rx_valid = 1; s0_rx_data = 8'h11;
    #1;
    chk("stall_data", {m_rx_valid, m_rx_data}, {1'b1, 8'h11});
    step();
    s0_rx_valid = 0;
    chk("stall_done_s1", {s1_rx_ready, grant}, {1'b0, 2'b01});
    step();
    chk("stall_idle", grant, 0);
    step();
    chk("stall_grant1", {grant, m_rx_data}, {2'b10, 8'h02});
    step();
    s1_rx_valid = 0;
    m_tx_valid = 1; m_tx_data = 8'h77; s1_tx_ready = 1;
    #1;
    chk("stall_resp1", {s1_tx_valid, s1_tx_data, s0_tx_valid},
        {1'b1, 8'h77, 1'b0});
    step();
    m_tx_valid = 0;
    step();
    chk("stall_end", grant, 0);

    // Reset while waiting in RESP.
    do_reset();
    m_rx_ready = 1;
    s0_rx_valid = 1; s0_rx_data = 8'h02;
    step();
    step();
    s0_rx_valid = 0;
    m_tx_valid = 1; m_tx_data = 8'hE1;
    #1;
    chk("rresp_active", {s0_tx_valid, s0_tx_data, m_tx_ready},
        {1'b1, 8'hE1, 1'b0});
    m_areset = 1;
    step();
    chk("rresp_cleared", all_out(), 0);
`ifdef UARTPROBE_ARB_STATS_EN
    chk("rresp_stats", {stat0, stat1}, 0);
`endif
    m_areset = 0;
    m_tx_valid = 0;
    s0_rx_valid = 1; s0_rx_data = 8'h00;
    s1_rx_valid = 1; s1_rx_data = 8'h00;
    step();
    chk("rresp_last", grant, 2'b01);
    clear_in();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
